// File: rtl/camera_standby_seq.sv
// ---------------------------------------------------------------------------
// camera_standby_seq
//
// Camera power-down / wake sequencer. It sits between the power-on sequencer
// and the camera pins. In RUN the power-on outputs are passed through with a
// one-cycle register delay. A standby request drains SCCB traffic, asserts
// camera reset, then asserts power-down. Dropping the request runs the wake
// sequence (release power-down, release reset, re-enable SCCB init).
//
// Parameters (clk_50M cycles, 1 .. 2^21-1):
//   T_DRAIN_TMO  maximum wait for sccb_busy to fall
//   T_RST2PWDN   reset-low hold before camera_pwnd rises
//   T_PWDN2RST   camera_pwnd low to camera reset release
//   T_RST2INIT   camera reset release to initial_en
//
// Ports:
//   clk_50M      in   system clock
//   reset        in   asynchronous active-high reset
//   pod_rstn     in   reset from power-on sequencer
//   pod_pwnd     in   power-down from power-on sequencer
//   pod_init_en  in   SCCB init enable from power-on sequencer
//   sleep_req    in   level: 1 = standby, 0 = run
//   sccb_busy    in   SCCB transaction in progress
//   camera_rstn  out  camera reset, active-low, registered
//   camera_pwnd  out  camera power-down, active-high, registered
//   initial_en   out  SCCB init enable, registered
//   standby      out  1 only while in OFF
//   seq_busy     out  1 in any state other than RUN and OFF
//   drain_err    out  sticky drain-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module camera_standby_seq #(
  parameter int unsigned T_DRAIN_TMO = 1_000_000,
  parameter int unsigned T_RST2PWDN  = 50_000,
  parameter int unsigned T_PWDN2RST  = 65_536,
  parameter int unsigned T_RST2INIT  = 1_048_575
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic pod_rstn,
  input  logic pod_pwnd,
  input  logic pod_init_en,
  input  logic sleep_req,
  input  logic sccb_busy,
  output logic camera_rstn,
  output logic camera_pwnd,
  output logic initial_en,
  output logic standby,
  output logic seq_busy,
  output logic drain_err
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_RST_HOLD,
    S_OFF,
    S_WAKE_PWDN,
    S_WAKE_RST
  } state_t;

  // A timed state exits when the counter reaches T-1, so it lasts T cycles.
  localparam logic [20:0] LP_DRAIN_LAST = 21'(T_DRAIN_TMO - 1);
  localparam logic [20:0] LP_HOLD_LAST  = 21'(T_RST2PWDN - 1);
  localparam logic [20:0] LP_PWDN_LAST  = 21'(T_PWDN2RST - 1);
  localparam logic [20:0] LP_INIT_LAST  = 21'(T_RST2INIT - 1);

  state_t      r_state;
  logic [20:0] r_cnt;
  logic        r_camera_rstn;
  logic        r_camera_pwnd;
  logic        r_initial_en;
  logic        r_standby;
  logic        r_seq_busy;
  logic        r_drain_err;

  // Outputs are assigned together with the state transition, so each one is
  // a registered decode of the next state and moves on the same edge.
  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the pre-edge values; blocking would let later lines see new state.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_camera_rstn <= 1'b0;
      r_camera_pwnd <= 1'b1;
      r_initial_en  <= 1'b0;
      r_standby     <= 1'b0;
      r_seq_busy    <= 1'b0;
      r_drain_err   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (sleep_req) begin
            // Pins hold their last pass-through values; only init is cut.
            r_state      <= S_DRAIN;
            r_cnt        <= '0;
            r_initial_en <= 1'b0;
            r_seq_busy   <= 1'b1;
          end else begin
            r_camera_rstn <= pod_rstn;
            r_camera_pwnd <= pod_pwnd;
            r_initial_en  <= pod_init_en;
          end
        end

        S_DRAIN: begin
          if (!sccb_busy || (r_cnt == LP_DRAIN_LAST)) begin
            // Timeout path: proceed anyway, but remember it happened.
            if (sccb_busy) begin
              r_drain_err <= 1'b1;
            end
            r_state       <= S_RST_HOLD;
            r_cnt         <= '0;
            r_camera_rstn <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end

        S_RST_HOLD: begin
          if (r_cnt == LP_HOLD_LAST) begin
            r_state       <= S_OFF;
            r_cnt         <= '0;
            r_camera_pwnd <= 1'b1;
            r_standby     <= 1'b1;
            r_seq_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end

        S_OFF: begin
          if (!sleep_req) begin
            r_state       <= S_WAKE_PWDN;
            r_cnt         <= '0;
            r_camera_pwnd <= 1'b0;
            r_standby     <= 1'b0;
            r_seq_busy    <= 1'b1;
          end
        end

        S_WAKE_PWDN: begin
          if (r_cnt == LP_PWDN_LAST) begin
            r_state       <= S_WAKE_RST;
            r_cnt         <= '0;
            r_camera_rstn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end

        S_WAKE_RST: begin
          if (r_cnt == LP_INIT_LAST) begin
            // Re-enter pass-through: outputs follow pod_* and are never forced
            // high, in case the power-on sequencer has not finished yet.
            r_state       <= S_RUN;
            r_cnt         <= '0;
            r_camera_rstn <= pod_rstn;
            r_camera_pwnd <= pod_pwnd;
            r_initial_en  <= pod_init_en;
            r_seq_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 21'd1;
          end
        end

        default: begin
          r_state       <= S_RUN;
          r_cnt         <= '0;
          r_camera_rstn <= 1'b0;
          r_camera_pwnd <= 1'b1;
          r_initial_en  <= 1'b0;
          r_standby     <= 1'b0;
          r_seq_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign camera_rstn = r_camera_rstn;
  assign camera_pwnd = r_camera_pwnd;
  assign initial_en  = r_initial_en;
  assign standby     = r_standby;
  assign seq_busy    = r_seq_busy;
  assign drain_err   = r_drain_err;

endmodule
